modinv_helper_compare_multi: RTL and testbench
==============================================

// Module: modinv_helper_compare_multi
// PURPOSE
//  Parametrised multi-word comparator/flag unit for the binary modular-inversion datapath.
//  Scans operand buffers u and v from the most-significant word down, one word per cycle.
//  Produces full three-way u<>v ordering, v==1 / u==1, zero and parity flags in one pass.
//  Supports configurable word width, depth and buffer read latency. Sits beside the invertor FSM.
// PARAMETERS
//  WORD_W       32  bits per buffer word
//  NUM_WORDS     9  words per operand (>=1); word 0 is least significant
//  ADDR_BITS     4  buffer address width, >= clog2(NUM_WORDS)
//  RD_LATENCY    1  cycles from address to data on u_din/v_din (1..3)
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  rst_n      in   1          synchronous active-low reset
//  ena        in   1          start request, sampled only while rdy=1
//  rdy        out  1          1 = idle, ready to accept ena
//  u_addr     out  ADDR_BITS  u buffer read address
//  v_addr     out  ADDR_BITS  v buffer read address (always == u_addr)
//  u_din      in   WORD_W     u buffer read data
//  v_din      in   WORD_W     v buffer read data
//  flags_vld  out  1          1 = flags below reflect the last completed scan
//  u_lt_v     out  1          u < v
//  u_eq_v     out  1          u == v
//  u_gt_v     out  1          u > v
//  u_eq_1     out  1          u == 1
//  v_eq_1     out  1          v == 1
//  u_is_zero  out  1          u == 0
//  v_is_zero  out  1          v == 0
//  u_is_even  out  1          ~u[0]
//  v_is_even  out  1          ~v[0]
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, rdy=1, flags_vld=0, all flag outputs 0,
//    addr=NUM_WORDS-1. Reset mid-scan aborts; IDLE on the next cycle, no partial flags.
//  - FSM: IDLE -> SCAN on ena&rdy; SCAN -> DRAIN after address 0 issued;
//    DRAIN -> IDLE after last data word captured. ena outside IDLE ignored.
//  - Start edge E0: flags_vld<=0, all sticky comparison state cleared.
//  - Cycle i=1..NUM_WORDS after E0: address NUM_WORDS-i presented; after 0, address holds 0
//    (no wrap) until IDLE, then returns to NUM_WORDS-1.
//  - Data for cycle-i address is valid in cycle i+RD_LATENCY; tracked by a RD_LATENCY-deep
//    valid/index shift register, not by din content.
//  - Per captured word pair (unsigned WORD_W compare, MSW first):
//    u<>v: first unequal word sets lt or gt (sticky); equal if none by last word.
//    v<>1, u<>1: word 0 compared with 1, others with 0; any nonzero upper word -> not 1.
//    zero: OR-reduce of all words. parity: bit 0 of word 0.
//  - Result registers updated at the edge ending cycle NUM_WORDS+RD_LATENCY;
//    next cycle rdy=1, flags_vld=1. Busy for exactly NUM_WORDS+RD_LATENCY cycles (default 10).
//  - Exactly one of u_lt_v/u_eq_v/u_gt_v is 1 when flags_vld=1. Flags hold until next start.
//  - ena on the same cycle rdy returns high starts a new scan (back-to-back, no gap cycle).
//  - NUM_WORDS=1: single word, SCAN lasts one cycle; all rules above still apply.
// TESTING
//  1. u=v=0x1 (all upper words 0) -> u_eq_v=1, u_eq_1=v_eq_1=1, even=0/0, rdy after 10 cycles.
//  2. u MSW=0x80000000 rest 0, v=0xFFFF_FFFF in words 0..7 -> u_gt_v=1 resolved at MSW.
//  3. u=v except word 0 (u=0x2, v=0x3) -> u_lt_v=1, u_is_even=1, v_is_even=0.
//  4. v word 0=1, word 5=0x10 -> v_eq_1=0; v all zero -> v_is_zero=1, v_eq_1=0.
//  5. rst_n low at cycle 4 of scan -> rdy=1, flags_vld=0, flags 0 next cycle; ena during SCAN ignored.
//  6. RD_LATENCY=3, NUM_WORDS=4, WORD_W=16, back-to-back ena -> rdy low exactly 7 cycles each.

Source files
------------

// File: rtl/modinv_helper_compare_multi.sv
// Multi-word u/v comparator and flag unit for the binary modular-inversion datapath.
// Scans both operand buffers MSW-first, one word per cycle, and produces all flags in one pass.
module modinv_helper_compare_multi #(
  parameter int WORD_W     = 32,
  parameter int NUM_WORDS  = 9,
  parameter int ADDR_BITS  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  output logic                 rdy,
  output logic [ADDR_BITS-1:0] u_addr,
  output logic [ADDR_BITS-1:0] v_addr,
  input  logic [WORD_W-1:0]    u_din,
  input  logic [WORD_W-1:0]    v_din,
  output logic                 flags_vld,
  output logic                 u_lt_v,
  output logic                 u_eq_v,
  output logic                 u_gt_v,
  output logic                 u_eq_1,
  output logic                 v_eq_1,
  output logic                 u_is_zero,
  output logic                 v_is_zero,
  output logic                 u_is_even,
  output logic                 v_is_even
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                                 state_reg;
  logic [ADDR_BITS-1:0]                   addr_reg;
  logic [RD_LATENCY-1:0]                  vld_sr_reg;
  logic [RD_LATENCY-1:0][ADDR_BITS-1:0]   idx_sr_reg;
  logic                                   lt_reg, gt_reg;
  logic                                   u_up_nz_reg, v_up_nz_reg;

  logic                 cap;
  logic [ADDR_BITS-1:0] cap_idx;
  logic                 lt_next, gt_next;

  assign u_addr  = addr_reg;
  assign v_addr  = addr_reg;
  assign cap     = vld_sr_reg[RD_LATENCY-1];
  assign cap_idx = idx_sr_reg[RD_LATENCY-1];

  // The first unequal word (from the top) decides the ordering; later words cannot override it.
  assign lt_next = lt_reg | (~gt_reg & (u_din < v_din));
  assign gt_next = gt_reg | (~lt_reg & (u_din > v_din));

  // Tracks which issued address the buffer data belongs to, independent of the data itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr_reg <= '0;
      idx_sr_reg <= '0;
    end else begin
      vld_sr_reg[0] <= (state_reg == SCAN);
      idx_sr_reg[0] <= addr_reg;
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_sr_reg[k] <= vld_sr_reg[k-1];
        idx_sr_reg[k] <= idx_sr_reg[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      addr_reg    <= LAST_ADDR;
      rdy         <= 1'b1;
      flags_vld   <= 1'b0;
      lt_reg      <= 1'b0;
      gt_reg      <= 1'b0;
      u_up_nz_reg <= 1'b0;
      v_up_nz_reg <= 1'b0;
      u_lt_v      <= 1'b0;
      u_eq_v      <= 1'b0;
      u_gt_v      <= 1'b0;
      u_eq_1      <= 1'b0;
      v_eq_1      <= 1'b0;
      u_is_zero   <= 1'b0;
      v_is_zero   <= 1'b0;
      u_is_even   <= 1'b0;
      v_is_even   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ena) begin
            state_reg   <= SCAN;
            rdy         <= 1'b0;
            flags_vld   <= 1'b0;
            lt_reg      <= 1'b0;
            gt_reg      <= 1'b0;
            u_up_nz_reg <= 1'b0;
            v_up_nz_reg <= 1'b0;
          end
        end
        SCAN: begin
          if (addr_reg == '0) state_reg <= DRAIN;
          else                addr_reg  <= addr_reg - 1'b1;
        end
        default: ;
      endcase

      if (cap) begin
        lt_reg      <= lt_next;
        gt_reg      <= gt_next;
        u_up_nz_reg <= u_up_nz_reg | (|u_din);
        v_up_nz_reg <= v_up_nz_reg | (|v_din);
        // Word 0 arrives last, so its capture completes the scan.
        if (cap_idx == '0) begin
          state_reg <= IDLE;
          addr_reg  <= LAST_ADDR;
          rdy       <= 1'b1;
          flags_vld <= 1'b1;
          u_lt_v    <= lt_next;
          u_gt_v    <= gt_next;
          u_eq_v    <= ~lt_next & ~gt_next;
          u_eq_1    <= ~u_up_nz_reg & (u_din == WORD_W'(1));
          v_eq_1    <= ~v_up_nz_reg & (v_din == WORD_W'(1));
          u_is_zero <= ~(u_up_nz_reg | (|u_din));
          v_is_zero <= ~(v_up_nz_reg | (|v_din));
          u_is_even <= ~u_din[0];
          v_is_even <= ~v_din[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_modinv_helper_compare_multi.sv
// Bench for modinv_helper_compare_multi: default instance plus a 4x16-bit, latency-3 instance,
// each fed from a modelled buffer with a read pipeline; results checked through a scoreboard.
module tb_modinv_helper_compare_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Instance A: defaults (32-bit, 9 words, latency 1)
  logic        a_ena, a_rdy, a_vld;
  logic [3:0]  a_uaddr, a_vaddr;
  logic [31:0] a_udin, a_vdin;
  logic        a_lt, a_eq, a_gt, a_u1, a_v1, a_uz, a_vz, a_ue, a_ve;
  logic [287:0] ua, va;

  // Instance B: 16-bit, 4 words, latency 3
  logic        b_ena, b_rdy, b_vld;
  logic [1:0]  b_uaddr, b_vaddr;
  logic [15:0] b_udin, b_vdin;
  logic        b_lt, b_eq, b_gt, b_u1, b_v1, b_uz, b_vz, b_ue, b_ve;
  logic [63:0] ub, vb;
  logic [15:0] b_pu [3];
  logic [15:0] b_pv [3];

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  modinv_helper_compare_multi dut_a (
    .clk(clk), .rst_n(rst_n), .ena(a_ena), .rdy(a_rdy),
    .u_addr(a_uaddr), .v_addr(a_vaddr), .u_din(a_udin), .v_din(a_vdin),
    .flags_vld(a_vld), .u_lt_v(a_lt), .u_eq_v(a_eq), .u_gt_v(a_gt),
    .u_eq_1(a_u1), .v_eq_1(a_v1), .u_is_zero(a_uz), .v_is_zero(a_vz),
    .u_is_even(a_ue), .v_is_even(a_ve)
  );

  modinv_helper_compare_multi #(.WORD_W(16), .NUM_WORDS(4), .ADDR_BITS(2), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(b_ena), .rdy(b_rdy),
    .u_addr(b_uaddr), .v_addr(b_vaddr), .u_din(b_udin), .v_din(b_vdin),
    .flags_vld(b_vld), .u_lt_v(b_lt), .u_eq_v(b_eq), .u_gt_v(b_gt),
    .u_eq_1(b_u1), .v_eq_1(b_v1), .u_is_zero(b_uz), .v_is_zero(b_vz),
    .u_is_even(b_ue), .v_is_even(b_ve)
  );

  // Buffer models: registered reads with the configured latency
  always @(posedge clk) begin
    a_udin <= ua[32*a_uaddr +: 32];
    a_vdin <= va[32*a_vaddr +: 32];
    b_pu[0] <= ub[16*b_uaddr +: 16];
    b_pv[0] <= vb[16*b_vaddr +: 16];
    b_pu[1] <= b_pu[0];
    b_pv[1] <= b_pv[0];
    b_pu[2] <= b_pu[1];
    b_pv[2] <= b_pv[1];
  end
  assign b_udin = b_pu[2];
  assign b_vdin = b_pv[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Reference: whole-operand arithmetic, {lt,eq,gt,u==1,v==1,u==0,v==0,u even,v even}
  function automatic logic [8:0] exp_flags(input logic [287:0] u, input logic [287:0] v);
    return {u < v, u == v, u > v, u == 288'd1, v == 288'd1,
            u == 288'd0, v == 288'd0, ~u[0], ~v[0]};
  endfunction

  function automatic logic [287:0] rand_wide();
    logic [287:0] r;
    for (int k = 0; k < 9; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic start_a(input logic [287:0] u, input logic [287:0] v, input bit push);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_rdy) break;
    end
    if (!a_rdy) check("a_rdy_timeout", 32'(a_rdy), 32'd1);
    ua = u;
    va = v;
    a_ena = 1'b1;
    if (push) qa.push_back(exp_flags(u, v));
    @(posedge clk);
    #1 a_ena = 1'b0;
  endtask

  task automatic start_b(input logic [63:0] u, input logic [63:0] v);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_rdy) break;
    end
    if (!b_rdy) check("b_rdy_timeout", 32'(b_rdy), 32'd1);
    ub = u;
    vb = v;
    b_ena = 1'b1;
    qb.push_back(exp_flags(288'(u), 288'(v)));
    @(posedge clk);
    #1 b_ena = 1'b0;
  endtask

  // Monitor A: scoreboard pop on flags_vld rise, busy-length per scan
  initial begin
    int  busy = 0;
    bit  skip = 1'b0;
    bit  vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        skip = 1'b1;
        vprev = 1'b0;
      end else begin
        if (a_vld && !vprev) begin
          if (qa.size() == 0) check("a_sb_empty", 32'd1, 32'd0);
          else check("a_flags", 32'({a_lt, a_eq, a_gt, a_u1, a_v1, a_uz, a_vz, a_ue, a_ve}),
                     32'(qa.pop_front()));
        end
        vprev = a_vld;
        if (!a_rdy) busy++;
        else begin
          if (busy != 0 && !skip) check("a_busy", 32'(busy), 32'd10);
          busy = 0;
          skip = 1'b0;
        end
      end
    end
  end

  // Monitor B: as A, plus a one-cycle rdy gap between back-to-back scans
  initial begin
    int  busy = 0;
    int  hi = 0;
    bit  seen = 1'b0;
    bit  vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        hi = 0;
        seen = 1'b0;
        vprev = 1'b0;
      end else begin
        if (b_vld && !vprev) begin
          if (qb.size() == 0) check("b_sb_empty", 32'd1, 32'd0);
          else check("b_flags", 32'({b_lt, b_eq, b_gt, b_u1, b_v1, b_uz, b_vz, b_ue, b_ve}),
                     32'(qb.pop_front()));
        end
        vprev = b_vld;
        if (!b_rdy) begin
          if (hi > 0 && seen) check("b_gap", 32'(hi), 32'd1);
          hi = 0;
          busy++;
        end else begin
          if (busy != 0) begin
            check("b_busy", 32'(busy), 32'd7);
            seen = 1'b1;
          end
          busy = 0;
          hi++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [287:0] x;
    rst_n = 1'b0;
    a_ena = 1'b0;
    b_ena = 1'b0;
    ua = '0; va = '0; ub = '0; vb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_rdy",   32'(a_rdy), 32'd1);
    check("rst_a_vld",   32'(a_vld), 32'd0);
    check("rst_a_flags", 32'({a_lt, a_eq, a_gt, a_u1, a_v1, a_uz, a_vz, a_ue, a_ve}), 32'd0);
    check("rst_a_addr",  32'(a_uaddr), 32'd8);
    check("rst_a_vaddr", 32'(a_vaddr), 32'd8);
    check("rst_b_rdy",   32'(b_rdy), 32'd1);
    check("rst_b_addr",  32'(b_uaddr), 32'd3);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases, each starting in the first cycle rdy is high
    start_a(288'd1, 288'd1, 1'b1);
    start_a(288'h8000_0000 << 256, (288'd1 << 256) - 288'd1, 1'b1);
    x = rand_wide();
    start_a({x[287:32], 32'h2}, {x[287:32], 32'h3}, 1'b1);
    start_a(rand_wide(), (288'h10 << 160) | 288'd1, 1'b1);
    start_a(rand_wide() | 288'd1, 288'd0, 1'b1);
    start_a(288'd0, 288'd1, 1'b1);
    x = rand_wide();
    start_a(x, x, 1'b1);
    // ena pulsed mid-scan must be ignored
    repeat (3) @(posedge clk);
    #1 a_ena = 1'b1;
    @(posedge clk);
    #1 a_ena = 1'b0;
    for (int i = 0; i < 3; i++) start_a(rand_wide(), rand_wide(), 1'b1);

    // Reset during cycle 4 of a scan aborts it
    start_a(rand_wide(), rand_wide(), 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_rdy",   32'(a_rdy), 32'd1);
    check("abort_vld",   32'(a_vld), 32'd0);
    check("abort_flags", 32'({a_lt, a_eq, a_gt, a_u1, a_v1, a_uz, a_vz, a_ue, a_ve}), 32'd0);
    check("abort_addr",  32'(a_uaddr), 32'd8);
    @(posedge clk);
    #1 rst_n = 1'b1;
    start_a(288'd5, 288'd1 << 100, 1'b1);

    for (int i = 0; i < 100 && qa.size() != 0; i++) @(negedge clk);
    check("a_drained", 32'(qa.size()), 32'd0);

    // Instance B: back-to-back scans
    start_b(64'h0001_0000_0000_0001, 64'h0001_0000_0000_0001);
    start_b(64'd1, 64'd0);
    start_b({$urandom, $urandom}, {$urandom, $urandom});
    start_b(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
    start_b({32'h1234_5678, 32'h0000_0002}, {32'h1234_5678, 32'h0000_0003});

    for (int i = 0; i < 100 && qb.size() != 0; i++) @(negedge clk);
    check("b_drained", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
